// File: rtl/add_sub_predicates_pipelined_pkg.sv
// Shared definitions for the pipelined adder/subtractor with compare predicates.
// Holds the default operand width and the operation encoding of the input_sub bit.
package add_sub_predicates_pipelined_pkg;

  localparam int DEFAULT_WORD_WIDTH = 16;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/add_sub_predicates_pipelined_carryin.sv
// Recovers the carry into every bit position of a ripple add from the operands and the sum.
// The sum bit is a ^ b ^ c_in, so XOR-ing the operands back out leaves the carry vector.
module CarryIn_Binary #(
  parameter int WORD_WIDTH = 16
) (
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic [WORD_WIDTH-1:0] sum,
  output logic [WORD_WIDTH-1:0] carryin
);

  assign carryin = a ^ b ^ sum;

endmodule

// File: rtl/add_sub_predicates_pipelined.sv
// Two-stage adder/subtractor with valid/ready flow control.
// Produces the sum, MSB carries, signed overflow and registered A-vs-B compare predicates.
module add_sub_predicates_pipelined
  import add_sub_predicates_pipelined_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] input_A,
  input  logic [WORD_WIDTH-1:0] input_B,
  input  logic                  input_sub,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_sum,
  output logic                  output_carry_out,
  output logic                  output_carry_in,
  output logic                  output_overflow,
  output logic                  output_eq,
  output logic                  output_lt_unsigned,
  output logic                  output_lt_signed
);

  localparam logic [WORD_WIDTH-1:0] ZERO = {WORD_WIDTH{1'b0}};
  localparam int MSB = WORD_WIDTH - 1;

  // Stage 1 state
  logic                  valid1;
  logic [WORD_WIDTH-1:0] a1;
  logic [WORD_WIDTH-1:0] b_eff1;
  logic                  sub1;
  logic [WORD_WIDTH-1:0] sum1;
  logic                  carry_out1;

  // Stage 2 state
  logic                  valid2;

  logic                  ready1;
  logic                  load1;
  logic                  load2;

  logic [WORD_WIDTH-1:0] b_eff;
  logic [WORD_WIDTH:0]   raw_sum;

  logic [WORD_WIDTH-1:0] carryin;
  logic                  overflow;
  logic                  is_sub;
  logic                  eq_next;
  logic                  lt_unsigned_next;
  logic                  lt_signed_next;

  // Stage 2 can move on only when the consumer takes its beat, so stage 1 sees
  // free space either when stage 2 is empty or is being drained this cycle.
  assign ready1      = !valid2 || output_ready;
  assign input_ready = !valid1 || ready1;
  assign load1       = input_valid && input_ready;
  assign load2       = valid1 && ready1;

  // Subtraction is A + ~B + 1; the +1 enters as the carry-in of bit 0.
  assign b_eff   = input_B ^ {WORD_WIDTH{input_sub}};
  assign raw_sum = {1'b0, input_A} + {1'b0, b_eff} + {{WORD_WIDTH{1'b0}}, input_sub};

  always_ff @(posedge clock) begin
    if (clear) begin
      valid1     <= 1'b0;
      a1         <= ZERO;
      b_eff1     <= ZERO;
      sub1       <= 1'b0;
      sum1       <= ZERO;
      carry_out1 <= 1'b0;
    end else begin
      if (input_ready) begin
        valid1 <= input_valid;
      end
      if (load1) begin
        a1         <= input_A;
        b_eff1     <= b_eff;
        sub1       <= input_sub;
        sum1       <= raw_sum[WORD_WIDTH-1:0];
        carry_out1 <= raw_sum[WORD_WIDTH];
      end
    end
  end

  CarryIn_Binary #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_carryin (
    .a       (a1),
    .b       (b_eff1),
    .sum     (sum1),
    .carryin (carryin)
  );

  // For subtraction carry_out is "no borrow", so its inverse is the unsigned A < B.
  assign overflow         = carryin[MSB] ^ carry_out1;
  assign is_sub           = (op_e'(sub1) == OP_SUB);
  assign eq_next          = is_sub && (sum1 == ZERO);
  assign lt_unsigned_next = is_sub && !carry_out1;
  assign lt_signed_next   = is_sub && (sum1[MSB] ^ overflow);

  always_ff @(posedge clock) begin
    if (clear) begin
      valid2             <= 1'b0;
      output_sum         <= ZERO;
      output_carry_out   <= 1'b0;
      output_carry_in    <= 1'b0;
      output_overflow    <= 1'b0;
      output_eq          <= 1'b0;
      output_lt_unsigned <= 1'b0;
      output_lt_signed   <= 1'b0;
    end else begin
      if (ready1) begin
        valid2 <= valid1;
      end
      if (load2) begin
        output_sum         <= sum1;
        output_carry_out   <= carry_out1;
        output_carry_in    <= carryin[MSB];
        output_overflow    <= overflow;
        output_eq          <= eq_next;
        output_lt_unsigned <= lt_unsigned_next;
        output_lt_signed   <= lt_signed_next;
      end
    end
  end

  assign output_valid = valid2;

endmodule

// File: tb/tb_add_sub_predicates_pipelined.sv
// Directed-vector bench for the 8-bit pipelined adder/subtractor: arithmetic corners,
// stalled streaming and mid-stream clear, all against hand-computed expectations.
module tb_add_sub_predicates_pipelined;

  logic       clock = 1'b0;
  logic       clear;
  logic       input_valid;
  logic       input_ready;
  logic [7:0] input_A;
  logic [7:0] input_B;
  logic       input_sub;
  logic       output_valid;
  logic       output_ready;
  logic [7:0] output_sum;
  logic       output_carry_out;
  logic       output_carry_in;
  logic       output_overflow;
  logic       output_eq;
  logic       output_lt_unsigned;
  logic       output_lt_signed;

  int vectors     = 0;
  int miscompares = 0;

  add_sub_predicates_pipelined #(
    .WORD_WIDTH(8)
  ) dut (
    .clock              (clock),
    .clear              (clear),
    .input_valid        (input_valid),
    .input_ready        (input_ready),
    .input_A            (input_A),
    .input_B            (input_B),
    .input_sub          (input_sub),
    .output_valid       (output_valid),
    .output_ready       (output_ready),
    .output_sum         (output_sum),
    .output_carry_out   (output_carry_out),
    .output_carry_in    (output_carry_in),
    .output_overflow    (output_overflow),
    .output_eq          (output_eq),
    .output_lt_unsigned (output_lt_unsigned),
    .output_lt_signed   (output_lt_signed)
  );

  always #5 clock = ~clock;

  // flags = {carry_out, carry_in, overflow, eq, lt_unsigned, lt_signed}
  function automatic logic [5:0] flags();
    return {output_carry_out, output_carry_in, output_overflow,
            output_eq, output_lt_unsigned, output_lt_signed};
  endfunction

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic [5:0] flg;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, sum: 8'h80, flg: 6'b011000};
    tbl[1] = '{a: 8'h05, b: 8'h05, sub: 1'b1, sum: 8'h00, flg: 6'b110100};
    tbl[2] = '{a: 8'h80, b: 8'h01, sub: 1'b1, sum: 8'h7F, flg: 6'b101001};
    tbl[3] = '{a: 8'h01, b: 8'hFF, sub: 1'b1, sum: 8'h02, flg: 6'b000010};
    tbl[4] = '{a: 8'h3C, b: 8'h00, sub: 1'b1, sum: 8'h3C, flg: 6'b110000};
    tbl[5] = '{a: 8'hFF, b: 8'h02, sub: 1'b0, sum: 8'h01, flg: 6'b110000};
    tbl[6] = '{a: 8'h02, b: 8'h05, sub: 1'b1, sum: 8'hFD, flg: 6'b000011};
    tbl[7] = '{a: 8'h7F, b: 8'h80, sub: 1'b1, sum: 8'hFF, flg: 6'b011010};
  end

  task automatic test_reset();
    clear        = 1'b1;
    input_valid  = 1'b0;
    input_A      = 8'h00;
    input_B      = 8'h00;
    input_sub    = 1'b0;
    output_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (output_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_output_valid got %b want 0", output_valid);
    end
    vectors++;
    if (input_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_input_ready got %b want 1", input_ready);
    end
    vectors++;
    if ({output_sum, flags()} !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_data got sum=%h flags=%b want 00/000000", output_sum, flags());
    end
    clear = 1'b0;
  endtask

  task automatic test_arith();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      input_valid = 1'b1;
      input_A     = tbl[i].a;
      input_B     = tbl[i].b;
      input_sub   = tbl[i].sub;
      #1;
      vectors++;
      if (input_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL arith%0d_input_ready got %b want 1", i, input_ready);
      end
      @(posedge clock);
      @(negedge clock);
      input_valid = 1'b0;
      vectors++;
      if (output_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL arith%0d_latency_early got output_valid=%b want 0", i, output_valid);
      end
      @(posedge clock);
      @(negedge clock);
      vectors++;
      if (output_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL arith%0d_latency got output_valid=%b want 1", i, output_valid);
      end
      vectors++;
      if (output_sum !== tbl[i].sum) begin
        miscompares++;
        $display("FAIL arith%0d_sum got %h want %h", i, output_sum, tbl[i].sum);
      end
      vectors++;
      if (flags() !== tbl[i].flg) begin
        miscompares++;
        $display("FAIL arith%0d_flags got %b want %b", i, flags(), tbl[i].flg);
      end
    end
  endtask

  task automatic test_back_to_back();
    int         sent = 0;
    int         recv = 0;
    logic [7:0] held = 8'h00;
    logic [7:0] exp_sum;
    logic       acc;
    logic       fire;
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      @(negedge clock);
      output_ready = !(cyc >= 2 && cyc <= 4);
      input_valid  = (sent < 6);
      input_A      = 8'(8'h10 + sent);
      input_B      = 8'(sent);
      input_sub    = 1'b0;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        vectors++;
        if (input_ready !== 1'b0 || output_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_cyc%0d got input_ready=%b output_valid=%b want 0/1",
                   cyc, input_ready, output_valid);
        end
        if (cyc == 2) begin
          held = output_sum;
        end else begin
          vectors++;
          if (output_sum !== held) begin
            miscompares++;
            $display("FAIL stall_hold_cyc%0d got %h want %h", cyc, output_sum, held);
          end
        end
      end
      acc  = input_valid && input_ready;
      fire = output_valid && output_ready;
      if (fire) begin
        exp_sum = 8'(8'h10 + 2 * recv);
        vectors++;
        if (output_sum !== exp_sum || output_carry_out !== 1'b0) begin
          miscompares++;
          $display("FAIL stream_beat%0d got sum=%h cout=%b want %h/0",
                   recv, output_sum, output_carry_out, exp_sum);
        end
        recv++;
      end
      @(posedge clock);
      if (acc) sent++;
    end
    vectors++;
    if (recv != 6 || held !== 8'h10) begin
      miscompares++;
      $display("FAIL stream_count got recv=%0d held=%h want 6/10", recv, held);
    end
    input_valid  = 1'b0;
    output_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (output_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_no_duplicate got output_valid=%b want 0", output_valid);
    end
  endtask

  task automatic test_clear_midstream();
    logic seen = 1'b0;
    output_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      input_valid = 1'b1;
      input_A     = 8'hA0 + 8'(i);
      input_B     = 8'h11;
      input_sub   = 1'b0;
      @(posedge clock);
    end
    @(negedge clock);
    input_valid  = 1'b0;
    output_ready = 1'b0;
    clear        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clear        = 1'b0;
    output_ready = 1'b1;
    #1;
    vectors++;
    if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_state got output_valid=%b input_ready=%b want 0/1",
               output_valid, input_ready);
    end
    vectors++;
    if (output_sum !== 8'h00) begin
      miscompares++;
      $display("FAIL clear_sum got %h want 00", output_sum);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (output_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_discard got stale beat=%b want 0", seen);
    end
    @(negedge clock);
    input_valid = 1'b1;
    input_A     = 8'h09;
    input_B     = 8'h03;
    input_sub   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    input_valid = 1'b0;
    vectors++;
    if (output_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_clear_early got output_valid=%b want 0", output_valid);
    end
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if (output_valid !== 1'b1 || output_sum !== 8'h06 || flags() !== 6'b110000) begin
      miscompares++;
      $display("FAIL post_clear_beat got valid=%b sum=%h flags=%b want 1/06/110000",
               output_valid, output_sum, flags());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_clear_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
